// File: rtl/vec_exec_seq_if.sv
// Request/response bundle for vec_exec_seq: one valid/ready handshake into the block
// and one out of it, plus the operand and result vectors.
interface vec_exec_seq_if #(
    parameter int DW    = 32,
    parameter int VLMAX = 8
);
    localparam int VW = $clog2(VLMAX + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [VW-1:0]         vl;
    logic                  use_scalar;
    logic [VLMAX*DW-1:0]   src1;
    logic [VLMAX*DW-1:0]   src2;
    logic [DW-1:0]         scalar;
    logic                  out_valid;
    logic                  out_ready;
    logic [VLMAX*DW-1:0]   result;
    logic [VW-1:0]         out_vl;

    modport master (
        output in_valid, op, vl, use_scalar, src1, src2, scalar, out_ready,
        input  in_ready, out_valid, result, out_vl
    );

    modport slave (
        input  in_valid, op, vl, use_scalar, src1, src2, scalar, out_ready,
        output in_ready, out_valid, result, out_vl
    );
endinterface

// File: rtl/vec_exec_seq.sv
// Multi-beat vector ALU: processes LANES elements per cycle and holds the result until taken.
// Optional macro VEC_EXEC_SAT_EN makes ADD/SUB saturate to signed DW limits instead of wrapping.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready; the result
// transfers on a rising edge where out_valid && out_ready. Operands and result are held
// stable by the side driving valid until that transfer edge.
module vec_exec_seq #(
    parameter int DW    = 32,
    parameter int LANES = 4,
    parameter int VLMAX = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_exec_seq_if.slave  bus,
    output logic [1:0]     state_dbg
);
    localparam int VW     = $clog2(VLMAX + 1);
    localparam int NBEATS = VLMAX / LANES;
    localparam int BW     = $clog2(NBEATS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [2:0]          op_r;
    logic [VW-1:0]       vl_r;
    logic [VLMAX*DW-1:0] src1_r;
    logic [VLMAX*DW-1:0] src2_r;
    logic [VLMAX*DW-1:0] result_r;
    logic [BW-1:0]       beat_r;
    logic                out_valid_r;
    logic [VW-1:0]       vl_eff_in;
    logic                last_beat;
    logic [DW-1:0]       lane_res [LANES];

    function automatic logic [DW-1:0] arith(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic sub);
`ifdef VEC_EXEC_SAT_EN
        logic [DW:0] x;
        x = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
        // Sign bits of the widened sum disagree only on signed overflow.
        if (x[DW] != x[DW-1])
            return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return x[DW-1:0];
`else
        return sub ? (a - b) : (a + b);
`endif
    endfunction

    function automatic logic [DW-1:0] elem_op(input logic [2:0] o, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (o)
            3'd0:    r = arith(a, b, 1'b0);
            3'd1:    r = arith(a, b, 1'b1);
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign vl_eff_in = (bus.vl > VW'(VLMAX)) ? VW'(VLMAX) : bus.vl;
    assign last_beat = (int'(beat_r) == ((int'(vl_r) + LANES - 1) / LANES) - 1);

    // Lanes past the effective length are forced to zero rather than computed.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_res[l] = '0;
            if ((int'(beat_r) * LANES + l) < int'(vl_r))
                lane_res[l] = elem_op(op_r,
                                      src1_r[(int'(beat_r) * LANES + l) * DW +: DW],
                                      src2_r[(int'(beat_r) * LANES + l) * DW +: DW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_r        <= '0;
            vl_r        <= '0;
            src1_r      <= '0;
            src2_r      <= '0;
            result_r    <= '0;
            beat_r      <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r     <= bus.op;
                        vl_r     <= vl_eff_in;
                        src1_r   <= bus.src1;
                        for (int i = 0; i < VLMAX; i++)
                            src2_r[i*DW +: DW] <= bus.use_scalar ? bus.scalar : bus.src2[i*DW +: DW];
                        result_r <= '0;
                        beat_r   <= '0;
                        if (vl_eff_in == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++)
                        result_r[(int'(beat_r) * LANES + l) * DW +: DW] <= lane_res[l];
                    if (last_beat) begin
                        beat_r      <= '0;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        beat_r <= beat_r + BW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.out_vl    = vl_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_vec_exec_seq.sv
// Directed, table-driven bench for vec_exec_seq plus hand sequences for stall and mid-run reset.
module tb_vec_exec_seq;
  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int VLMAX = 8;
  localparam int W     = VLMAX * DW;
  localparam int NV    = 10;

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   vl;
    logic         us;
    logic [31:0]  sc;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] er;
    logic [3:0]   evl;
    int           lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];
  vec_t       tbl[NV];

  vec_exec_seq_if #(.DW(DW), .VLMAX(VLMAX)) bus ();

  vec_exec_seq #(.DW(DW), .LANES(LANES), .VLMAX(VLMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic chk_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] vl, input logic us,
                              input logic [31:0] sc, input logic [3:0] evl, input int lat);
    vec_t v;
    v.op = op; v.vl = vl; v.us = us; v.sc = sc; v.evl = evl; v.lat = lat;
    v.s1 = '0; v.s2 = '0; v.er = '0;
    return v;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.op = '0; bus.vl = '0; bus.use_scalar = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.scalar = '0; bus.out_ready = 1'b0;
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < VLMAX; i++) begin
      bus.src1[i*DW +: DW] = $urandom();
      bus.src2[i*DW +: DW] = $urandom();
    end
    bus.scalar     = $urandom();
    bus.op         = 3'($urandom_range(0, 7));
    bus.vl         = 4'($urandom_range(0, 15));
    bus.use_scalar = 1'($urandom_range(0, 1));
  endtask

  // Drives one request, accepts it, changes inputs afterwards and waits for out_valid.
  task automatic start_and_wait(input vec_t v, input string tag);
    int lat;
    logic [W-1:0] exp;
    bus.op = v.op; bus.vl = v.vl; bus.use_scalar = v.us; bus.scalar = v.sc;
    bus.src1 = v.s1; bus.src2 = v.s2; bus.in_valid = 1'b1;
    chk_b({tag, "_in_ready_idle"}, bus.in_ready, 1'b1);
    exp_q.push_back(v.er);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    chk_b({tag, "_in_ready_busy"}, bus.in_ready, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_i({tag, "_latency"}, lat, v.lat);
    exp = exp_q.pop_front();
    chk_v({tag, "_result"}, bus.result, exp);
    chk_i({tag, "_out_vl"}, int'(bus.out_vl), int'(v.evl));
  endtask

  task automatic handoff(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk_b({tag, "_in_ready_handoff"}, bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk_b({tag, "_out_valid_after"}, bus.out_valid, 1'b0);
    chk_b({tag, "_in_ready_after"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    // vector table
    tbl[0] = mk(3'd0, 4'd8, 1'b0, 32'd0, 4'd8, 3);
    tbl[1] = mk(3'd1, 4'd5, 1'b1, 32'd1, 4'd5, 3);
    tbl[2] = mk(3'd0, 4'd1, 1'b0, 32'd0, 4'd1, 2);
    tbl[3] = mk(3'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1);
    tbl[4] = mk(3'd2, 4'd15, 1'b0, 32'd0, 4'd8, 3);
    tbl[5] = mk(3'd3, 4'd3, 1'b0, 32'd0, 4'd3, 2);
    tbl[6] = mk(3'd4, 4'd4, 1'b0, 32'd0, 4'd4, 2);
    tbl[7] = mk(3'd5, 4'd8, 1'b1, 32'd0, 4'd8, 3);
    tbl[8] = mk(3'd1, 4'd2, 1'b0, 32'd0, 4'd2, 2);
    tbl[9] = mk(3'd6, 4'd8, 1'b0, 32'd0, 4'd8, 3);
    for (int i = 0; i < VLMAX; i++) begin
      tbl[0].s1[i*DW +: DW] = 32'(i);
      tbl[0].s2[i*DW +: DW] = 32'(10 * i);
      tbl[0].er[i*DW +: DW] = 32'(11 * i);
      tbl[1].s1[i*DW +: DW] = 32'd100;
      tbl[1].s2[i*DW +: DW] = 32'(77 + i);
      tbl[1].er[i*DW +: DW] = (i < 5) ? 32'd99 : 32'd0;
      tbl[2].s1[i*DW +: DW] = 32'(i + 1);
      tbl[2].s2[i*DW +: DW] = 32'd1;
      tbl[3].s1[i*DW +: DW] = 32'(i + 5);
      tbl[3].s2[i*DW +: DW] = 32'(i);
      tbl[4].s1[i*DW +: DW] = 32'hFF00_FF00 ^ 32'(i);
      tbl[4].s2[i*DW +: DW] = 32'h0F0F_0F0F;
      tbl[4].er[i*DW +: DW] = 32'h0F00_0F00 + 32'(i);
      tbl[5].s1[i*DW +: DW] = 32'd1 << i;
      tbl[5].s2[i*DW +: DW] = 32'h100;
      tbl[6].s1[i*DW +: DW] = 32'hAAAA_AAAA;
      tbl[6].s2[i*DW +: DW] = 32'hFFFF_FFFF;
      tbl[6].er[i*DW +: DW] = (i < 4) ? 32'h5555_5555 : 32'd0;
      tbl[7].s1[i*DW +: DW] = 32'(i - 4);
      tbl[7].s2[i*DW +: DW] = 32'h8000_0000;
      tbl[7].er[i*DW +: DW] = (i < 4) ? 32'd1 : 32'd0;
      tbl[9].s1[i*DW +: DW] = 32'(i + 3);
      tbl[9].s2[i*DW +: DW] = 32'(i);
    end
    tbl[2].s1[31:0] = 32'h7FFF_FFFF;
    tbl[5].er[95:0] = {32'h104, 32'h102, 32'h101};
    tbl[8].s1[63:0] = {32'd5, 32'h8000_0000};
    tbl[8].s2[63:0] = {32'd7, 32'd1};
`ifdef VEC_EXEC_SAT_EN
    tbl[2].er[31:0] = 32'h7FFF_FFFF;
    tbl[8].er[63:0] = {32'hFFFF_FFFE, 32'h8000_0000};
`else
    tbl[2].er[31:0] = 32'h8000_0000;
    tbl[8].er[63:0] = {32'hFFFF_FFFE, 32'h7FFF_FFFF};
`endif

    // reset state
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_b("reset_out_valid", bus.out_valid, 1'b0);
    chk_v("reset_result", bus.result, '0);
    chk_i("reset_out_vl", int'(bus.out_vl), 0);
    chk_i("reset_state", int'(state_dbg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_b("post_reset_in_ready", bus.in_ready, 1'b1);

    // table-driven vectors
    for (int k = 0; k < NV; k++) begin
      start_and_wait(tbl[k], $sformatf("vec%0d", k));
      handoff($sformatf("vec%0d", k));
    end

    // DONE stall with inputs toggling
    start_and_wait(tbl[0], "stall");
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk); #1;
      chk_v($sformatf("stall_result_c%0d", c), bus.result, tbl[0].er);
      chk_b($sformatf("stall_out_valid_c%0d", c), bus.out_valid, 1'b1);
      chk_b($sformatf("stall_in_ready_c%0d", c), bus.in_ready, 1'b0);
      chk_i($sformatf("stall_out_vl_c%0d", c), int'(bus.out_vl), 8);
    end
    handoff("stall");

    // reset in the first RUN cycle discards the operation
    bus.op = 3'd0; bus.vl = 4'd8; bus.use_scalar = 1'b0;
    bus.src1 = tbl[0].s1; bus.src2 = tbl[0].s2; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_i("midrun_state_run", int'(state_dbg), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_b("midrun_out_valid", bus.out_valid, 1'b0);
    chk_v("midrun_result", bus.result, '0);
    chk_i("midrun_state", int'(state_dbg), 0);
    chk_i("midrun_out_vl", int'(bus.out_vl), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk_b($sformatf("midrun_no_result_c%0d", c), bus.out_valid, 1'b0);
    end
    chk_b("midrun_in_ready", bus.in_ready, 1'b1);
    start_and_wait(tbl[5], "after_reset");
    handoff("after_reset");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
